// File: rtl/add_post_pkg.sv
// add_post_pkg: shared geometry and state encoding for the Add write-back path.
//   S          - RTM banks (one write enable each)
//   R          - int8 lanes per bank per word
//   RTM_DEPTH  - words per bank; ADDR_W address bits
//   DATA_W     - width of one full RTM word across all banks
package add_post_pkg;

  localparam int S         = 8;
  localparam int R         = 16;
  localparam int RTM_DEPTH = 4096;
  localparam int ADDR_W    = $clog2(RTM_DEPTH);
  localparam int DATA_W    = S * R * 8;

  // One-hot controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_RUN   = 3'b010,
    ST_FLUSH = 3'b100
  } state_e;

  // Every bank is written at the same word address.
  function automatic logic [S*ADDR_W-1:0] rep_addr(input logic [ADDR_W-1:0] addr);
    return {S{addr}};
  endfunction

endpackage

// File: rtl/add_post_shift_reg.sv
// shift_reg: fixed-depth pipeline of WIDTH-bit words, cleared by rst.
//   clk, rst - clock and synchronous active-high reset
//   d        - word entering the pipe
//   q        - word DEPTH cycles later (combinational pass-through when DEPTH = 0)
module shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift one stage per cycle; reset empties the whole pipe.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/add_post.sv
// add_post: write-back end of the element-wise Add datapath.
// Takes requantized int8 result beats from the PPU array and writes one RTM
// word per valid beat at consecutive addresses, length-checks the stream
// against the instruction and signals completion.
//   clk, rst                      - clock, synchronous active-high reset
//   start_pulse, C_addr,
//   len_minus_1                   - instruction start, first address, words-1
//   ppus_outs, _vld, _last        - result beats from the PPUs
//   rtm_wr_vld/_last/_en/_addr,
//   rtm_din                       - RTM write port, 1+OUT_REG cycles after the beat
//   busy, done_pulse, err_len     - status to the Add controller
module add_post
  import add_post_pkg::*;
#(
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pulse,
  input  logic [ADDR_W-1:0]     C_addr,
  input  logic [ADDR_W-1:0]     len_minus_1,
  input  logic [DATA_W-1:0]     ppus_outs,
  input  logic                  ppus_outs_vld,
  input  logic                  ppus_outs_last,
  output logic                  rtm_wr_vld,
  output logic                  rtm_wr_last,
  output logic [S-1:0]          rtm_wr_en,
  output logic [S*ADDR_W-1:0]   rtm_wr_addr,
  output logic [DATA_W-1:0]     rtm_din,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  err_len
);

  localparam int   BUS_W      = 2 + S + S*ADDR_W + DATA_W;
  localparam logic FLUSH_LAST = 1'(OUT_REG);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic                err_len_q, err_len_d;
  logic                flush_cnt_q, flush_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_vld_q, wr_vld_d;
  logic                wr_last_q, wr_last_d;
  logic [S-1:0]        wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                cnt_hit_s;
  logic                beat_term_s;
  logic [BUS_W-1:0]    bus_in_s;
  logic [BUS_W-1:0]    bus_out_s;

  // Next-state, write-stage and status computation.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    err_len_d   = err_len_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    wr_vld_d    = 1'b0;
    wr_last_d   = 1'b0;
    wr_en_d     = '0;
    wr_addr_d   = wr_addr_q;
    din_d       = din_q;
    cnt_hit_s   = (wr_cnt_q == len_q);
    beat_term_s = ppus_outs_last || cnt_hit_s;

    if (start_pulse) begin
      // A start wins over everything, including a beat in the same cycle.
      state_d     = ST_RUN;
      next_addr_d = C_addr;
      len_d       = len_minus_1;
      wr_cnt_d    = '0;
      err_len_d   = 1'b0;
      flush_cnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (ppus_outs_vld) begin
            wr_vld_d    = 1'b1;
            wr_last_d   = beat_term_s;
            wr_en_d     = {S{1'b1}};
            wr_addr_d   = next_addr_q;
            din_d       = ppus_outs;
            // RTM_DEPTH is a power of two, so natural overflow is the wrap.
            next_addr_d = next_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            wr_cnt_d    = wr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (beat_term_s) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = 1'b0;
              // Early last or missing last both flag a length error.
              err_len_d   = err_len_q | (ppus_outs_last != cnt_hit_s);
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // Wait until the final write has left the output pipe.
          if (flush_cnt_q == FLUSH_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Busy stays high through the cycle that carries done_pulse.
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // State, counters, status and first write stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      err_len_q   <= 1'b0;
      flush_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      err_len_q   <= err_len_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_vld_q    <= wr_vld_d;
      wr_last_q   <= wr_last_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      din_q       <= din_d;
    end
  end

  assign bus_in_s = {wr_vld_q, wr_last_q, wr_en_q, rep_addr(wr_addr_q), din_q};

  // Optional extra register stage on the whole write bus so fields stay aligned.
  shift_reg #(
    .WIDTH (BUS_W),
    .DEPTH (OUT_REG)
  ) u_out_pipe (
    .clk (clk),
    .rst (rst),
    .d   (bus_in_s),
    .q   (bus_out_s)
  );

  assign {rtm_wr_vld, rtm_wr_last, rtm_wr_en, rtm_wr_addr, rtm_din} = bus_out_s;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign err_len    = err_len_q;

endmodule

// File: doc/add_post.md
Name: add_post

Overview:
- Write-back end of the element-wise Add datapath.
- Accepts requantized int8 result vectors from the PPU array and writes them to the RTM at a destination address, one RTM word per valid beat.
- Length-checks the stream against the instruction and reports completion to the Add controller.
- Mirrors the read side that feeds the PPUs: same RTM word geometry, same vld/last framing.

Parameters:
S, 8, number of RTM banks (one write enable per bank)
R, 16, int8 lanes per bank per word
RTM_DEPTH, 4096, words per RTM bank; ADDR_W = clog2(RTM_DEPTH)
OUT_REG, 0, extra output pipeline stages on RTM write ports (0 or 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_pulse  in  1  one-cycle instruction start
C_addr  in  ADDR_W  destination RTM address of first result word
len_minus_1  in  ADDR_W  result words minus 1
ppus_outs  in  S*R*8  int8 results, lane i at [i*8+:8]
ppus_outs_vld  in  1  result beat valid
ppus_outs_last  in  1  final result beat (qualified by vld)
rtm_wr_vld  out  1  write beat valid
rtm_wr_last  out  1  final write beat
rtm_wr_en  out  S  per-bank write enable
rtm_wr_addr  out  S*ADDR_W  per-bank address, all banks identical
rtm_din  out  S*R*8  write data
busy  out  1  instruction in progress
done_pulse  out  1  one cycle after final write leaves the block
err_len  out  1  sticky length mismatch, cleared by start_pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal counters 0, pipeline contents cleared.
- States: IDLE, RUN, FLUSH.
  - IDLE: start_pulse -> RUN.
  - RUN: terminating beat -> FLUSH.
  - FLUSH: waits 1+OUT_REG cycles for the final write to leave, then asserts done_pulse and goes to IDLE.
- start_pulse, any state:
  - Latch next_addr<=C_addr, len_reg<=len_minus_1, wr_cnt<=0, err_len<=0; state<=RUN.
  - Restarting in RUN/FLUSH aborts the old instruction: no done_pulse for it; writes already in the pipeline still drain.
- RUN, beat with ppus_outs_vld=1:
  - Register rtm_din<=ppus_outs, rtm_wr_addr<=next_addr replicated to all S banks, rtm_wr_en<=all ones, rtm_wr_vld<=1.
  - next_addr+1 wraps modulo RTM_DEPTH; wr_cnt+1.
- Terminating beat: vld && (ppus_outs_last || wr_cnt==len_reg).
  - rtm_wr_last=1 on that write.
  - err_len<=1 if ppus_outs_last != (wr_cnt==len_reg).
  - Later beats are dropped until the next start.
- Latency: ppus_outs_vld to rtm_wr_vld is 1+OUT_REG cycles; data, addr, en, last travel together. No backpressure: every accepted beat is written.
- Non-write cycles: rtm_wr_vld and rtm_wr_en are 0; rtm_din and rtm_wr_addr hold their last value.
- vld in IDLE or FLUSH: ignored, no write.
- vld in the same cycle as start_pulse: beat discarded.
- busy=1 from the cycle after start_pulse through the cycle done_pulse is high.
- rst mid-operation: immediate IDLE, pending writes discarded (wr_vld=0 next cycle), no done_pulse.
- len_minus_1=0: single-beat instruction; done_pulse 2+OUT_REG cycles after that beat's vld.

Decomposition:
- Shared package: S, R, RTM_DEPTH, ADDR_W, state encodings (IDLE/RUN/FLUSH, one-hot).
- Sub-module: OUT_REG staging reuses the existing shift_reg (depth OUT_REG) on rtm_wr_* buses. No new sub-module.

Test Plan:
- start C_addr=100, len_minus_1=3; 4 consecutive vld beats, last on beat 4 -> writes at 100..103 one cycle after each beat, wr_last on 103, done_pulse 1 cycle later, err_len=0.
- C_addr=RTM_DEPTH-2, len_minus_1=3, gapped vld -> addresses 4094,4095,0,1 with gaps preserved, all en=8'hFF.
- len_minus_1=3, last on beat 2 -> 2 writes, wr_last on 2nd, err_len=1, done_pulse; beats 3-4 produce no writes.
- len_minus_1=1, last never asserted, 3 beats -> 2 writes, wr_last on 2nd, err_len=1, 3rd beat dropped.
- rst asserted after 2 of 4 beats -> next cycle all outputs 0, busy=0, no done_pulse; new start with C_addr=7 writes from 7.
- OUT_REG=1, single beat len_minus_1=0 -> write at cycle+2, done_pulse at cycle+3; vld coincident with start discarded.
